// File: rtl/bp_resolve_unit_pkg.sv
// rtl/bp_resolve_unit_pkg.sv - shared codes, types and helpers for the branch resolve unit
package bp_resolve_unit_pkg;

    localparam int          InstAddrBus = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    localparam logic [1:0] BP_NONE      = 2'b00;
    localparam logic [1:0] BP_NOT_TAKEN = 2'b01;
    localparam logic [1:0] BP_TAKEN     = 2'b10;

    typedef struct packed {
        logic                   pred;
        logic [InstAddrBus-1:0] pc;
        logic [InstAddrBus-1:0] target;
    } bp_entry_t;

    // Address fetch should have followed given the real outcome of this branch.
    function automatic logic [InstAddrBus-1:0] correct_addr(bp_entry_t e, logic taken);
        return taken ? e.target : e.pc + 32'd4;
    endfunction

endpackage

// File: rtl/bp_pred_fifo.sv
// rtl/bp_pred_fifo.sv - circular buffer of outstanding branch predictions with push/pop/clear
module bp_pred_fifo
    import bp_resolve_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  logic      clear,
    input  bp_entry_t wdata,
    output bp_entry_t rdata,
    output logic      full,
    output logic      empty
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    bp_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Clear wins over push/pop; the caller suppresses any push on a clearing cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bp_resolve_unit.sv
// rtl/bp_resolve_unit.sv - resolves queued branch predictions, trains the predictor, flushes on mispredict
// Optional statistics counters enabled by BP_RESOLVE_STATS_EN.
module bp_resolve_unit
    import bp_resolve_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic        push_pred_i,
    input  logic [31:0] push_pc_i,
    input  logic [31:0] push_target_i,
    input  logic        res_valid_i,
    input  logic        res_taken_i,
    input  logic        flush_i,
    output logic [1:0]  branch_taken_o,
    output logic        mispredict_o,
    output logic [31:0] redirect_addr_o,
    output logic        full_o,
    output logic        empty_o,
    output logic        overflow_o
`ifdef BP_RESOLVE_STATS_EN
    ,
    output logic [31:0] stat_resolved_o,
    output logic [31:0] stat_mispred_o
`endif
);

    bp_entry_t head;
    bp_entry_t wentry;
    logic      pop;
    logic      mispred_now;
    logic      push_acc;
    logic      clear;

    assign pop         = res_valid_i & ~empty_o & ~flush_i;
    assign mispred_now = pop & (head.pred != res_taken_i);
    // Everything behind a mispredicted head is wrong-path, including a same-cycle push.
    assign clear       = flush_i | mispred_now;
    assign push_acc    = push_i & ~clear & (~full_o | pop);
    assign wentry      = '{pred: push_pred_i, pc: push_pc_i, target: push_target_i};

    bp_pred_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_acc),
        .pop   (pop),
        .clear (clear),
        .wdata (wentry),
        .rdata (head),
        .full  (full_o),
        .empty (empty_o)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_taken_o  <= BP_NONE;
            mispredict_o    <= 1'b0;
            redirect_addr_o <= ZeroWord;
            overflow_o      <= 1'b0;
        end else begin
            branch_taken_o <= pop ? (res_taken_i ? BP_TAKEN : BP_NOT_TAKEN) : BP_NONE;
            mispredict_o   <= mispred_now;
            if (mispred_now) begin
                redirect_addr_o <= correct_addr(head, res_taken_i);
            end
            if (push_i & full_o & ~pop & ~flush_i) begin
                overflow_o <= 1'b1;
            end
        end
    end

`ifdef BP_RESOLVE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_resolved_o <= '0;
            stat_mispred_o  <= '0;
        end else begin
            if (pop)         stat_resolved_o <= stat_resolved_o + 32'd1;
            if (mispred_now) stat_mispred_o  <= stat_mispred_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bp_resolve_unit.sv
// tb/tb_bp_resolve_unit.sv - self-checking bench for bp_resolve_unit against a queue model
module tb_bp_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_i;
    logic        push_pred_i;
    logic [31:0] push_pc_i;
    logic [31:0] push_target_i;
    logic        res_valid_i;
    logic        res_taken_i;
    logic        flush_i;
    logic [1:0]  branch_taken_o;
    logic        mispredict_o;
    logic [31:0] redirect_addr_o;
    logic        full_o;
    logic        empty_o;
    logic        overflow_o;
`ifdef BP_RESOLVE_STATS_EN
    logic [31:0] stat_resolved_o;
    logic [31:0] stat_mispred_o;
    logic [31:0] e_nres;
    logic [31:0] e_nmis;
`endif

    bp_resolve_unit dut (
        .clk             (clk),
        .rst             (rst),
        .push_i          (push_i),
        .push_pred_i     (push_pred_i),
        .push_pc_i       (push_pc_i),
        .push_target_i   (push_target_i),
        .res_valid_i     (res_valid_i),
        .res_taken_i     (res_taken_i),
        .flush_i         (flush_i),
        .branch_taken_o  (branch_taken_o),
        .mispredict_o    (mispredict_o),
        .redirect_addr_o (redirect_addr_o),
        .full_o          (full_o),
        .empty_o         (empty_o),
        .overflow_o      (overflow_o)
`ifdef BP_RESOLVE_STATS_EN
        ,
        .stat_resolved_o (stat_resolved_o),
        .stat_mispred_o  (stat_mispred_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          pred;
        logic [31:0] pc;
        logic [31:0] tgt;
    } ent_t;

    ent_t        q[$];
    int          total = 0;
    int          bad   = 0;
    logic [1:0]  e_bt;
    logic        e_mp;
    logic [31:0] e_ra;
    logic        e_ov;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".bt"},    {30'd0, branch_taken_o}, {30'd0, e_bt});
        chk({tag, ".mp"},    {31'd0, mispredict_o},   {31'd0, e_mp});
        if (e_mp) chk({tag, ".ra"}, redirect_addr_o, e_ra);
        chk({tag, ".empty"}, {31'd0, empty_o},    {31'd0, q.size() == 0});
        chk({tag, ".full"},  {31'd0, full_o},     {31'd0, q.size() == 4});
        chk({tag, ".ovf"},   {31'd0, overflow_o}, {31'd0, e_ov});
`ifdef BP_RESOLVE_STATS_EN
        chk({tag, ".nres"},  stat_resolved_o, e_nres);
        chk({tag, ".nmis"},  stat_mispred_o,  e_nmis);
`endif
    endtask

    task automatic model_reset();
        q.delete();
        e_bt = 2'b00;
        e_mp = 1'b0;
        e_ra = 32'h0;
        e_ov = 1'b0;
`ifdef BP_RESOLVE_STATS_EN
        e_nres = 0;
        e_nmis = 0;
`endif
    endtask

    // One clock: drive inputs, predict the outcome from queue semantics, check after the edge.
    task automatic step(input string tag, input bit p, input bit pp, input logic [31:0] pc,
                        input logic [31:0] tgt, input bit r, input bit rt, input bit fl);
        ent_t h;
        bit   killed;
        push_i = p; push_pred_i = pp; push_pc_i = pc; push_target_i = tgt;
        res_valid_i = r; res_taken_i = rt; flush_i = fl;
        @(posedge clk);
        e_bt   = 2'b00;
        e_mp   = 1'b0;
        killed = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            if (r && q.size() > 0) begin
                h    = q.pop_front();
                e_bt = rt ? 2'b10 : 2'b01;
`ifdef BP_RESOLVE_STATS_EN
                e_nres++;
`endif
                if (h.pred != rt) begin
                    e_mp   = 1'b1;
                    e_ra   = rt ? h.tgt : h.pc + 32'd4;
                    killed = 1'b1;
                    q.delete();
`ifdef BP_RESOLVE_STATS_EN
                    e_nmis++;
`endif
                end
            end
            if (p && !killed) begin
                if (q.size() < 4) q.push_back('{pred: pp, pc: pc, tgt: tgt});
                else              e_ov = 1'b1;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0;
        push_i = 0; push_pred_i = 0; push_pc_i = 0; push_target_i = 0;
        res_valid_i = 0; res_taken_i = 0; flush_i = 0;
        model_reset();
        #12;
        check_all("reset");
        chk("reset.ra", redirect_addr_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        idle("idle", 10);

        // Correct taken prediction
        step("t1.push", 1, 1, 32'h100, 32'h140, 0, 0, 0);
        step("t1.res",  0, 0, 0, 0, 1, 1, 0);

        // Predicted taken, actually not taken
        step("t2.push", 1, 1, 32'h200, 32'h180, 0, 0, 0);
        step("t2.res",  0, 0, 0, 0, 1, 0, 0);
        idle("t2.after", 1);

        // Predicted not taken, actually taken: younger entries are wrong-path
        step("t3.p0",  1, 0, 32'h300, 32'h3F0, 0, 0, 0);
        step("t3.p1",  1, 1, 32'h304, 32'h500, 0, 0, 0);
        step("t3.p2",  1, 0, 32'h308, 32'h600, 0, 0, 0);
        step("t3.res", 0, 0, 0, 0, 1, 1, 0);
        step("t3.y1",  0, 0, 0, 0, 1, 1, 0);
        step("t3.y2",  0, 0, 0, 0, 1, 0, 0);

        // Fill, overflow, push+resolve while full, pointer wrap
        for (int i = 0; i < 4; i++) step("t4.fill", 1, 1, 32'h1000 + 32'(i * 4), 32'h2000, 0, 0, 0);
        step("t4.ovf", 1, 1, 32'h1010, 32'h2000, 0, 0, 0);
        for (int i = 0; i < 10; i++) step("t4.wrap", 1, 1, 32'h1100 + 32'(i * 4), 32'h2100, 1, 1, 0);
        for (int i = 0; i < 4; i++) step("t4.drain", 0, 0, 0, 0, 1, 1, 0);

        // Edge cases
        step("t5.res_empty", 0, 0, 0, 0, 1, 0, 0);
        step("t5.p",         1, 1, 32'h700, 32'h740, 0, 0, 0);
        step("t5.p",         1, 0, 32'h704, 32'h780, 0, 0, 0);
        step("t5.flush_res", 1, 1, 32'h708, 32'h7C0, 1, 0, 1);
        step("t5.after",     0, 0, 0, 0, 1, 1, 0);
        step("t5.full_mp",   1, 1, 32'h800, 32'h900, 0, 0, 0);
        step("t5.full_mp",   1, 1, 32'h804, 32'h900, 0, 0, 0);
        step("t5.full_mp",   1, 1, 32'h808, 32'h900, 0, 0, 0);
        step("t5.full_mp",   1, 1, 32'h80C, 32'h900, 0, 0, 0);
        step("t5.full_mp",   1, 1, 32'h810, 32'h900, 1, 0, 0);

        // Asynchronous reset mid-stream
        step("t6.p", 1, 1, 32'hA00, 32'hA40, 0, 0, 0);
        step("t6.p", 1, 0, 32'hA04, 32'hA80, 1, 0, 0);
        push_i = 1; res_valid_i = 1; res_taken_i = 1;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("t6.async");
        @(negedge clk);
        rst = 1'b1;
        idle("t6.idle", 2);

        // Randomized traffic, resolve outcome biased to agree with the head prediction
        for (int i = 0; i < 400; i++) begin
            bit p, pp, r, rt, fl;
            p  = ($urandom_range(3) != 0);
            pp = $urandom_range(1);
            r  = ($urandom_range(2) == 0);
            fl = ($urandom_range(23) == 0);
            if (q.size() > 0 && $urandom_range(4) != 0) rt = q[0].pred;
            else                                        rt = $urandom_range(1);
            step("rnd", p, pp, $urandom, $urandom, r, rt, fl);
        end
        idle("end", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_resolve_unit.md
Name: bp_resolve_unit

Overview:
- Execute-side partner of the IF-stage branch predictor.
- Holds each conditional-branch prediction made at fetch in an in-order queue.
- Compares each prediction against the actual outcome computed in execute.
- Returns a 2-bit taken/not-taken training code to the predictor's saturating counter, and issues a registered mispredict flush with the corrected fetch address.

Parameters:
- DEPTH, 4, number of outstanding predictions tracked; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH); queue pointer width.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous reset, active-low
- push_i  input  1  IF issued a conditional-branch (B-type) prediction this cycle
- push_pred_i  input  1  predicted taken (1) / not taken (0)
- push_pc_i  input  32  branch instruction address
- push_target_i  input  32  predicted-taken target
- res_valid_i  input  1  EX resolved the oldest outstanding conditional branch
- res_taken_i  input  1  actual outcome
- flush_i  input  1  external pipeline flush (trap/interrupt); discards all entries
- branch_taken_o  output  2  training code: 00 none, 01 not taken, 10 taken
- mispredict_o  output  1  one-cycle flush request to IF/ID
- redirect_addr_o  output  32  corrected fetch address, valid with mispredict_o
- full_o  output  1  queue holds DEPTH entries; IF must stall further B-type fetch
- empty_o  output  1  no outstanding entries
- overflow_o  output  1  sticky: push_i seen while full

Behaviour:
- Reset (rst low, asynchronous): pointers and count = 0, branch_taken_o = 00, mispredict_o = 0, redirect_addr_o = 0, overflow_o = 0. full_o = 0 and empty_o = 1, both combinational from count.
- Queue:
  - Circular buffer of {pred, pc, target}.
  - Write and read pointers are PTR_W bits and wrap modulo DEPTH.
  - count is PTR_W+1 bits.
- Push:
  - Accepted when push_i and not full, or when push_i, full and a resolve pops in the same cycle.
  - Push while full without a pop: the push is dropped and overflow_o is set. overflow_o clears only on reset.
- Resolve, when res_valid_i and not empty:
  - Pop the head entry.
  - Next cycle: branch_taken_o = 10 if res_taken_i, else 01.
  - Mispredict when pred != res_taken_i. mispredict_o = 1 for exactly one cycle.
  - redirect_addr_o = head target if actual outcome is taken, else head pc + 32'd4 (wraps modulo 2^32).
- Resolve when empty: ignored. branch_taken_o = 00, no mispredict.
- Mispredict queue handling: all entries younger than the head are wrong-path.
  - The queue is cleared (count = 0, rd_ptr = wr_ptr) in the same clock edge as the pop.
  - A push in that same cycle is discarded.
- Latency: all outputs registered, 1 cycle after res_valid_i. branch_taken_o and mispredict_o are zero in every cycle without a resolve.
- flush_i:
  - Clears the queue, and branch_taken_o/mispredict_o are 00/0 next cycle.
  - Has priority over a same-cycle resolve: no training, no mispredict.
  - A same-cycle push is discarded.
- Simultaneous push and resolve, no mispredict: count unchanged, both pointers advance.
- Reset asserted mid-operation: all state lost immediately; no pulse emitted.

Optional Feature:
- Macro: BP_RESOLVE_STATS_EN.
- Defined:
  - Adds outputs stat_resolved_o[31:0] and stat_mispred_o[31:0].
  - Each increments by 1 on every counted resolve and every mispredict respectively.
  - Wraps at 2^32; reset to 0.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines file:
  - BP_NONE = 2'b00, BP_NOT_TAKEN = 2'b01, BP_TAKEN = 2'b10 (the same codes the predictor consumes).
  - Existing ZeroWord, InstAddrBus.
- One natural sub-module: bp_pred_fifo. It is a parameterised circular buffer with push, pop, clear, full and empty.

Test Plan:
- Reset then idle: empty_o = 1, full_o = 0, branch_taken_o = 00, mispredict_o = 0 for 10 cycles.
- Push {pred = 1, pc = 0x100, tgt = 0x140}, resolve taken: next cycle branch_taken_o = 10, mispredict_o = 0, empty_o = 1.
- Push {pred = 1, pc = 0x200, tgt = 0x180}, resolve not taken: branch_taken_o = 01, mispredict_o = 1, redirect_addr_o = 0x204.
- Push pred = 0 (pc = 0x300, tgt = 0x3F0), then two further pushes; resolve taken:
  - redirect_addr_o = 0x3F0 and mispredict_o pulses once.
  - Queue empty next cycle.
  - Younger entries produce no training.
- Fill 4 entries:
  - full_o = 1; a 5th push sets overflow_o.
  - Push plus resolve while full keeps count = 4.
  - Pointers wrap correctly over 10 cycles.
- Edge cases:
  - Resolve on empty gives no output.
  - flush_i together with res_valid_i gives no output and an empty queue.
  - rst low mid-stream clears everything asynchronously.
